// File: rtl/sw_sched.sv
// rtl/sw_sched.sv - single-iteration iSLIP crossbar scheduler for the 4x4 switch
// Acks are the only lock state; connections hold until tail or MAXLEN timeout.
module sw_sched #(
  parameter int MAXLEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req0,
  input  logic [3:0] req1,
  input  logic [3:0] req2,
  input  logic [3:0] req3,
  input  logic       tail0,
  input  logic       tail1,
  input  logic       tail2,
  input  logic       tail3,
  output logic [3:0] ack0,
  output logic [3:0] ack1,
  output logic [3:0] ack2,
  output logic [3:0] ack3,
  output logic [3:0] err
);

  localparam int CW = (MAXLEN > 2) ? $clog2(MAXLEN) : 1;

  logic [3:0]    req [4];
  logic [3:0]    tail;
  logic [3:0]    ack_q [4];
  logic [1:0]    gptr [4];
  logic [1:0]    aptr [4];
  logic [CW-1:0] cnt [4];

  logic [3:0] in_lock;
  logic [3:0] out_lock;
  logic [3:0] gnt [4];   // gnt[j][i]: output j grants input i
  logic [3:0] acc [4];   // acc[i][j]: input i accepts output j
  logic       hit;
  logic [1:0] idx;

  assign req[0] = req0;
  assign req[1] = req1;
  assign req[2] = req2;
  assign req[3] = req3;
  assign tail   = {tail3, tail2, tail1, tail0};
  assign ack0   = ack_q[0];
  assign ack1   = ack_q[1];
  assign ack2   = ack_q[2];
  assign ack3   = ack_q[3];

  always_comb begin
    in_lock  = '0;
    out_lock = '0;
    hit      = 1'b0;
    idx      = '0;
    for (int j = 0; j < 4; j++) gnt[j] = '0;
    for (int i = 0; i < 4; i++) acc[i] = '0;
    for (int i = 0; i < 4; i++) begin
      in_lock[i] = |ack_q[i];
      out_lock   = out_lock | ack_q[i];
    end
    // grant: round-robin over free requesting inputs, starting at gptr
    for (int j = 0; j < 4; j++) begin
      hit = 1'b0;
      for (int k = 0; k < 4; k++) begin
        idx = gptr[j] + 2'(k);
        if (!out_lock[j] && !hit && req[idx][j] && !in_lock[idx]) begin
          gnt[j][idx] = 1'b1;
          hit         = 1'b1;
        end
      end
    end
    // accept: round-robin over granting outputs, starting at aptr
    for (int i = 0; i < 4; i++) begin
      hit = 1'b0;
      for (int k = 0; k < 4; k++) begin
        idx = aptr[i] + 2'(k);
        if (!in_lock[i] && !hit && gnt[idx][i]) begin
          acc[i][idx] = 1'b1;
          hit         = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= '0;
      for (int i = 0; i < 4; i++) begin
        ack_q[i] <= '0;
        gptr[i]  <= '0;
        aptr[i]  <= '0;
        cnt[i]   <= '0;
      end
    end else begin
      err <= '0;
      for (int i = 0; i < 4; i++) begin
        if (in_lock[i]) begin
          if (tail[i]) begin
            ack_q[i] <= '0;
            cnt[i]   <= '0;
          end else if (cnt[i] == CW'(MAXLEN - 1)) begin
            ack_q[i] <= '0;
            cnt[i]   <= '0;
            err[i]   <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          ack_q[i] <= acc[i];
          cnt[i]   <= '0;
        end
        for (int j = 0; j < 4; j++) begin
          if (acc[i][j]) begin
            aptr[i] <= 2'(j + 1);
            gptr[j] <= 2'(i + 1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sw_sched.sv
// tb/tb_sw_sched.sv - directed and randomized checks of sw_sched against a matching model
module tb_sw_sched;

  localparam int MAXLEN = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] r [4];
  logic [3:0] t;
  logic [3:0] ack0, ack1, ack2, ack3, err;
  logic [15:0] ackv;

  int n_chk  = 0;
  int n_fail = 0;

  int m_out [4];
  int m_cnt [4];
  int m_gp  [4];
  int m_ap  [4];
  logic [3:0] m_err;

  assign ackv = {ack3, ack2, ack1, ack0};

  always #5 clk = ~clk;

  sw_sched #(.MAXLEN(MAXLEN)) dut (
    .clk(clk), .rst(rst),
    .req0(r[0]), .req1(r[1]), .req2(r[2]), .req3(r[3]),
    .tail0(t[0]), .tail1(t[1]), .tail2(t[2]), .tail3(t[3]),
    .ack0(ack0), .ack1(ack1), .ack2(ack2), .ack3(ack3),
    .err(err)
  );

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_out[i] = -1; m_cnt[i] = 0; m_gp[i] = 0; m_ap[i] = 0;
    end
    m_err = '0;
  endfunction

  // iSLIP rules from the pre-edge state: who each free output picks, then who each free input keeps
  function automatic void model_step();
    int g [4];
    int a [4];
    bit olock [4];
    for (int k = 0; k < 4; k++) begin g[k] = -1; a[k] = -1; olock[k] = 0; end
    for (int i = 0; i < 4; i++) if (m_out[i] >= 0) olock[m_out[i]] = 1;
    for (int j = 0; j < 4; j++)
      if (!olock[j])
        for (int k = 0; k < 4; k++) begin
          int i = (m_gp[j] + k) % 4;
          if (g[j] < 0 && m_out[i] < 0 && r[i][j]) g[j] = i;
        end
    for (int i = 0; i < 4; i++)
      if (m_out[i] < 0)
        for (int k = 0; k < 4; k++) begin
          int j = (m_ap[i] + k) % 4;
          if (a[i] < 0 && g[j] == i) a[i] = j;
        end
    m_err = '0;
    for (int i = 0; i < 4; i++) begin
      if (m_out[i] >= 0) begin
        if (t[i]) begin
          m_out[i] = -1; m_cnt[i] = 0;
        end else if (m_cnt[i] == MAXLEN - 1) begin
          m_out[i] = -1; m_cnt[i] = 0; m_err[i] = 1'b1;
        end else begin
          m_cnt[i]++;
        end
      end else if (a[i] >= 0) begin
        m_out[i] = a[i];
        m_cnt[i] = 0;
        m_gp[a[i]] = (i + 1) % 4;
        m_ap[i] = (a[i] + 1) % 4;
      end
    end
  endfunction

  function automatic logic [15:0] m_ack();
    logic [15:0] v = '0;
    for (int i = 0; i < 4; i++) if (m_out[i] >= 0) v[i*4 + m_out[i]] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) r[i] = '0;
    t = '0;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (ackv !== 16'h0 || err !== 4'h0) begin
      n_fail++; $display("FAIL reset_out ack=%h err=%h want ack=0000 err=0", ackv, err);
    end
    for (int j = 0; j < 4; j++) begin
      n_chk++;
      if (dut.gptr[j] !== 2'd0 || dut.aptr[j] !== 2'd0 || dut.cnt[j] !== '0) begin
        n_fail++; $display("FAIL reset_ptr[%0d] gptr=%0d aptr=%0d cnt=%0d want 0", j, dut.gptr[j], dut.aptr[j], dut.cnt[j]);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    r[0] = 4'b0010;
    tick();
    n_chk++;
    if (ackv !== 16'h0002) begin
      n_fail++; $display("FAIL single_ack ack=%h want 0002", ackv);
    end
    n_chk++;
    if (dut.gptr[1] !== 2'd1 || dut.aptr[0] !== 2'd2) begin
      n_fail++; $display("FAIL single_ptr gptr1=%0d aptr0=%0d want 1,2", dut.gptr[1], dut.aptr[0]);
    end
    r[0] = '0; t[0] = 1'b1;
    tick();
    t = '0;
    n_chk++;
    if (ackv !== 16'h0) begin
      n_fail++; $display("FAIL single_release ack=%h want 0000", ackv);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) r[i] = 4'b0001;
    for (int n = 0; n < 4; n++) begin
      tick();
      n_chk++;
      if (ackv !== (16'h1 << (4*n))) begin
        n_fail++; $display("FAIL rr_grant[%0d] ack=%h want %h", n, ackv, 16'h1 << (4*n));
      end
      t[n] = 1'b1; r[n] = '0;
      tick();
      t = '0;
      n_chk++;
      if (ackv !== 16'h0) begin
        n_fail++; $display("FAIL rr_idle[%0d] ack=%h want 0000", n, ackv);
      end
    end
  endtask

  task automatic test_permutation();
    do_reset();
    r[0] = 4'b0001; r[1] = 4'b0010; r[2] = 4'b0100; r[3] = 4'b1000;
    tick();
    for (int i = 0; i < 4; i++) r[i] = '0;
    for (int c = 1; c <= 5; c++) begin
      n_chk++;
      if (ackv !== 16'h8421) begin
        n_fail++; $display("FAIL perm_hold[%0d] ack=%h want 8421", c, ackv);
      end
      if (c == 5) t = 4'hf;
      tick();
    end
    t = '0;
    n_chk++;
    if (ackv !== 16'h0) begin
      n_fail++; $display("FAIL perm_release ack=%h want 0000", ackv);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    r[0] = 4'b0011; r[1] = 4'b0001;
    tick();
    n_chk++;
    if (ackv !== 16'h0001) begin
      n_fail++; $display("FAIL conflict_first ack=%h want 0001", ackv);
    end
    tick();
    n_chk++;
    if (ackv !== 16'h0001) begin
      n_fail++; $display("FAIL conflict_blocked ack=%h want 0001", ackv);
    end
    r[0] = '0; t[0] = 1'b1;
    tick();
    t = '0;
    n_chk++;
    if (ackv !== 16'h0) begin
      n_fail++; $display("FAIL conflict_idle ack=%h want 0000", ackv);
    end
    tick();
    n_chk++;
    if (ackv !== 16'h0010) begin
      n_fail++; $display("FAIL conflict_second ack=%h want 0010", ackv);
    end
    r[1] = '0; t[1] = 1'b1;
    tick();
    t = '0;
  endtask

  task automatic test_timeout();
    do_reset();
    r[2] = 4'b0100;
    for (int c = 1; c <= MAXLEN; c++) begin
      tick();
      n_chk++;
      if (ackv !== 16'h0400 || err !== 4'h0) begin
        n_fail++; $display("FAIL timeout_hold[%0d] ack=%h err=%h want 0400,0", c, ackv, err);
      end
    end
    tick();
    n_chk++;
    if (ackv !== 16'h0 || err !== 4'b0100) begin
      n_fail++; $display("FAIL timeout_release ack=%h err=%h want 0000,4", ackv, err);
    end
    tick();
    n_chk++;
    if (ackv !== 16'h0400 || err !== 4'h0) begin
      n_fail++; $display("FAIL timeout_rematch ack=%h err=%h want 0400,0", ackv, err);
    end
    r[2] = '0; t[2] = 1'b1;
    tick();
    t = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    r[1] = 4'b1000;
    tick();
    tick();
    n_chk++;
    if (ackv !== 16'h0080) begin
      n_fail++; $display("FAIL areset_pre ack=%h want 0080", ackv);
    end
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if (ackv !== 16'h0 || err !== 4'h0) begin
      n_fail++; $display("FAIL areset_out ack=%h err=%h want 0000,0", ackv, err);
    end
    for (int j = 0; j < 4; j++) begin
      n_chk++;
      if (dut.gptr[j] !== 2'd0 || dut.aptr[j] !== 2'd0) begin
        n_fail++; $display("FAIL areset_ptr[%0d] gptr=%0d aptr=%0d want 0", j, dut.gptr[j], dut.aptr[j]);
      end
    end
    test_single();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) r[i] = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) t[i] = ($urandom_range(0, 9) == 0);
      tick();
      n_chk++;
      if (ackv !== m_ack() || err !== m_err) begin
        n_fail++; $display("FAIL random[%0d] ack=%h err=%h want %h,%h", c, ackv, err, m_ack(), m_err);
      end
      for (int j = 0; j < 4; j++) begin
        n_chk++;
        if (dut.gptr[j] !== 2'(m_gp[j]) || dut.aptr[j] !== 2'(m_ap[j])) begin
          n_fail++; $display("FAIL random_ptr[%0d][%0d] gptr=%0d aptr=%0d want %0d,%0d", c, j, dut.gptr[j], dut.aptr[j], m_gp[j], m_ap[j]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) r[i] = '0;
    t = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_permutation();
    test_conflict();
    test_timeout();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_sched.md
Name: sw_sched

Overview:
- Crossbar scheduler for the 4x4 input-buffered packet switch. Replaces the four independent per-output arbiters with one single-iteration iSLIP matcher.
- Each cycle it takes the 4x4 request matrix from the input buffers and produces a conflict-free input-to-output matching.
- A matched connection is held until the packet's tail flit has been forwarded.
- The ack vectors drive input-buffer dequeue and crossbar select, the same way the per-output arbiter acks do today.

Parameters:
- MAXLEN, 16: maximum cycles a connection may be held without a tail. Range 2..255. Counter width is clog2(MAXLEN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0..req3  in  4 each  reqI[J]=1: input I's head packet requests output J.
- tail0..tail3  in  1 each  the flit input I forwards this cycle is the packet tail. Only meaningful while ackI!=0.
- ack0..ack3  out  4 each  ackI[J]=1: input I connected to output J. Registered, at most one bit set per vector, at most one input per output.
- err  out  4  err[I] pulses 1 cycle when input I's connection is forcibly released by timeout.

Behaviour:
- Reset (rst=0, async): all ackI=0, err=0, all grant pointers gptr[J]=0, all accept pointers aptr[I]=0, hold counters cnt[I]=0.
- State:
  - input I is locked iff ackI!=0; output J is locked iff some ackI[J]=1.
  - Lock state is the registered ack matrix only; no separate FSM register.
- Per-cycle matching (combinational on current state, registered at the edge):
  - Grant phase: each unlocked output J looks at unlocked inputs I with reqI[J]=1. It grants the first one at or after gptr[J], searching cyclically 0..3.
  - Accept phase: each unlocked input I looks at the outputs granting it. It accepts the first at or after aptr[I], searching cyclically.
  - Each accepted pair (I,J) sets ackI[J]=1 at the next edge.
  - Pointer update happens only on accept: gptr[J] <= (I+1) mod 4 and aptr[I] <= (J+1) mod 4. Pointers for non-accepted grants are unchanged.
- Latency: a request present in cycle t produces ack visible in cycle t+1 (1 edge).
- Hold:
  - While ackI!=0, reqI is ignored and ackI is unchanged.
  - cnt[I] increments each held cycle without tail, and is cleared whenever ackI==0.
- Release:
  - tailI=1 with ackI!=0 at an edge → ackI=0 after that edge, cnt[I]=0.
  - The freed input and output are not eligible in the cycle the tail is sampled, because matching uses pre-edge state. Minimum gap between connections on the same port is therefore one idle cycle.
- Timeout:
  - If ackI!=0, tailI=0 and cnt[I]==MAXLEN-1 at an edge: ackI=0 and err[I]=1 for exactly the next cycle.
  - A connection is therefore held at most MAXLEN cycles.
  - Tail and timeout in the same cycle counts as a normal release: err[I] stays 0.
- Boundary cases:
  - Single-flit packet: tail asserted in the first ack cycle → ack lasts exactly 1 cycle.
  - reqI=0 while unlocked: no grant, and the input's pointers do not move.
  - reqI may drop during a hold: the connection persists until tail or timeout.
  - tailI while ackI==0 is ignored.
  - Reset mid-connection clears all acks and pointers immediately (async). Partial packets are the input buffer's problem.
- Invariants:
  - Each column of the ack matrix has popcount ≤1.
  - Each ackI has popcount ≤1.
  - ack never changes for a locked pair except at release or timeout.

Test Plan:
1. Reset, then req0=4'b0010 with all others 0 → ack0=4'b0010 one cycle later. gptr[1]=1 and aptr[0]=2 after that edge.
2. req0..req3 all 4'b0001, pointers at 0, with the tail for each winner given on its first ack cycle → output 0 is served to inputs 0,1,2,3 in that order. Each ack lasts 1 cycle with one idle cycle between grants.
3. Full permutation req0=0001, req1=0010, req2=0100, req3=1000 → all four acks set in the same cycle. Hold for 5 cycles, tails on cycle 5 → all acks 0 on cycle 6.
4. Conflict: req0=0011 and req1=0001 with all pointers 0 → output0 and output1 both grant input 0. Input 0 accepts output 0 (ack0=0001) and input 1 gets nothing. Next cycle input 1 is still blocked by the lock on output 0. After tail0, input 1 gets ack1=0001.
5. MAXLEN=16, req2=0100, tail never asserted → ack2=0100 for exactly 16 cycles, then 0. err[2]=1 for one cycle; the input rematches after the idle cycle if still requesting.
6. Assert rst=0 asynchronously mid-hold with ack1=1000 → ack1=0 before the next clk edge, err=0, and every pointer 0. After release, the case 1 result repeats.
